pkt_fifo_sync: RTL and testbench
================================

# pkt_fifo_sync

Synchronous packet FIFO for the packet-filter datapath. It replaces the raw word FIFO wherever whole frames must be either kept or discarded. Words become visible to the reader only when their packet's last word has been written. A packet can be aborted mid-write, and a packet that overflows the buffer is dropped automatically, so no partial frame ever reaches the read side.

## Interface
- ADDR_WIDTH, 11, depth = 2**ADDR_WIDTH words; pointers are ADDR_WIDTH+1 bits.
- W_EL, 20, data word width.
- AFULL_SLACK, 4, `afull` asserts when free words <= AFULL_SLACK; legal range 1 .. 2**ADDR_WIDTH-1.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; asserting (0) clears all state immediately; deassertion is synchronised externally.
- wen  in  1  write strobe.
- wdata  in  W_EL  write word.
- wlast  in  1  qualifies `wen`: this word ends the packet.
- wabort  in  1  discard the packet currently being written.
- full  out  1  no free word.
- afull  out  1  free words <= AFULL_SLACK.
- ren  in  1  read strobe.
- rdata  out  W_EL  read word, registered.
- rlast  out  1  `rdata` is the last word of its packet.
- rvalid  out  1  `rdata`/`rlast` valid this cycle.
- empty  out  1  no committed word available.
- used  out  ADDR_WIDTH+1  words occupied, including uncommitted ones.
- pkt_cnt  out  ADDR_WIDTH+1  number of complete committed packets not yet fully read.
- drop_cnt  out  16  packets dropped by abort or overflow; saturates at 16'hFFFF.

## Operation
- State:
  - `wptr`: speculative write pointer.
  - `cptr`: commit pointer.
  - `rptr`: read pointer.
  - `err`: sticky overflow flag for the current packet.
- Storage is W_EL+1 bits per word; the extra bit holds `wlast`.
- Derived values:
  - `used` = wptr - rptr, modulo 2**(ADDR_WIDTH+1).
  - `full` = (used == 2**ADDR_WIDTH).
  - `afull` = (2**ADDR_WIDTH - used <= AFULL_SLACK).
  - `empty` = (cptr == rptr).
- Write decision per cycle, first match wins:
  1. wabort=1: wptr <= cptr; err <= 0; drop_cnt++. Any `wen` word this cycle is discarded.
  2. wen=1 and (full or err): the word is discarded and err <= 1. If wlast=1, then wptr <= cptr, err <= 0, drop_cnt++.
  3. wen=1: store {wlast, wdata} at wptr and increment wptr. If wlast=1, then cptr <= wptr+1 and pkt_cnt++.
- Read: ren=1 and !empty presents mem[rptr] on the next cycle with rvalid=1, and rptr++.
  - If the stored last bit is 1, pkt_cnt--.
  - ren while empty is ignored: rvalid=0, and rdata/rlast hold their previous values.
- A commit and the read of a last word in the same cycle leave pkt_cnt unchanged.
- Pointer comparisons use the MSB wrap bit, so full and empty are unambiguous across wrap-around.
- A packet longer than the depth always overflows and is dropped.
- A read never reaches an uncommitted word, because rptr stops at cptr.
- ren is independent of the write side. An abort never affects words already committed.

## Timing
- Reset values:
  - wptr = cptr = rptr = 0, err = 0.
  - full = 0, afull = 0, empty = 1, used = 0.
  - rvalid = 0, rdata = 0, rlast = 0.
  - pkt_cnt = 0, drop_cnt = 0.
- Reset applies asynchronously mid-packet; any partial packet is lost and not counted.
- full, afull, empty, used and pkt_cnt are functions of registered state only. They update the cycle after the causing edge, with no combinational path from wen or ren.
- Read latency is 1: ren sampled at edge N gives rdata/rlast/rvalid after edge N.
- Commit-to-visible latency is 1: wlast written at edge N makes empty=0 after edge N, and ren may be issued in that cycle.
- Throughput is one write and one read per cycle, sustained and simultaneous.
- Memory must infer as one simple dual-port block RAM with a registered read port.

## Test plan
- Reset, then write a 3-word packet (A, B, C with wlast on C) -> empty stays 1 through B and drops after C. pkt_cnt=1, used=3. Three reads return A, B, C with rlast only on C; then empty=1 and pkt_cnt=0.
- Write 2 words, then pulse wabort -> used returns to 0, empty stays 1, drop_cnt=1. The next packet writes and reads back intact.
- ADDR_WIDTH=4: write an 18-word packet -> full=1 at 16 words and err set. At wlast: used=0, drop_cnt=1, pkt_cnt=0, nothing readable.
- ADDR_WIDTH=4, AFULL_SLACK=4: write 12 words -> afull=1 with full=0. At 16 words full=1. A read of a committed word clears full the next cycle.
- Stream 100 single-word packets while reading every cycle across several pointer wraps -> data in order, rlast=1 on every word, pkt_cnt never exceeds 2, no drops.
- Assert reset mid-packet with committed data present -> all outputs reach their reset values immediately. Post-reset traffic is unaffected.

Source files
------------

// File: rtl/pkt_fifo_sync.sv
// Synchronous packet FIFO: words become readable only once their packet's
// last word is written. Aborted or overflowing packets are rolled back to the
// commit pointer, so the read side only ever sees whole frames.
module pkt_fifo_sync #(
  parameter int ADDR_WIDTH  = 11,
  parameter int W_EL        = 20,
  parameter int AFULL_SLACK = 4
) (
  input  logic                  clk,
  input  logic                  reset,     // asynchronous, active-low
  input  logic                  wen,
  input  logic [W_EL-1:0]       wdata,
  input  logic                  wlast,
  input  logic                  wabort,
  output logic                  full,
  output logic                  afull,
  input  logic                  ren,
  output logic [W_EL-1:0]       rdata,
  output logic                  rlast,
  output logic                  rvalid,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   used,
  output logic [ADDR_WIDTH:0]   pkt_cnt,
  output logic [15:0]           drop_cnt
);

  localparam int                PW      = ADDR_WIDTH + 1;
  localparam int                DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = PW'(DEPTH);
  localparam logic [ADDR_WIDTH:0] SLACK_C = PW'(AFULL_SLACK);
  localparam logic [ADDR_WIDTH:0] ONE_C   = PW'(1);

  // Storage: {last flag, data} per word
  logic [W_EL:0] mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are unambiguous
  logic [ADDR_WIDTH:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH:0] cptr_q, cptr_d;
  logic [ADDR_WIDTH:0] rptr_q, rptr_d;
  logic                err_q, err_d;
  logic [ADDR_WIDTH:0] cnt_q, cnt_d;
  logic [15:0]         drop_q, drop_d;
  logic                rvalid_q;
  logic [W_EL:0]       rword_q;

  logic [ADDR_WIDTH:0] used_s;
  logic [ADDR_WIDTH:0] free_s;
  logic                full_s;
  logic                afull_s;
  logic                empty_s;
  logic                rd_en_s;
  logic                rd_done_s;
  logic                mem_we_s;
  logic                commit_s;
  logic                drop_inc_s;

  // Status flags derived from registered state only
  always_comb begin
    used_s    = wptr_q - rptr_q;
    free_s    = DEPTH_C - used_s;
    full_s    = (used_s == DEPTH_C);
    afull_s   = (free_s <= SLACK_C);
    empty_s   = (cptr_q == rptr_q);
    // A last word was handed out on the previous edge; the internal packet
    // counter catches up one edge later, so subtract it here meanwhile.
    rd_done_s = rvalid_q & rword_q[W_EL];
  end

  // Write-side decision: abort, discard on overflow, or store
  always_comb begin
    wptr_d     = wptr_q;
    cptr_d     = cptr_q;
    err_d      = err_q;
    mem_we_s   = 1'b0;
    commit_s   = 1'b0;
    drop_inc_s = 1'b0;
    if (wabort) begin
      wptr_d     = cptr_q;
      err_d      = 1'b0;
      drop_inc_s = 1'b1;
    end else if (wen && (full_s || err_q)) begin
      if (wlast) begin
        wptr_d     = cptr_q;
        err_d      = 1'b0;
        drop_inc_s = 1'b1;
      end else begin
        err_d      = 1'b1;
      end
    end else if (wen) begin
      mem_we_s = 1'b1;
      wptr_d   = wptr_q + ONE_C;
      if (wlast) begin
        cptr_d   = wptr_q + ONE_C;
        commit_s = 1'b1;
      end else begin
        cptr_d   = cptr_q;
      end
    end else begin
      wptr_d = wptr_q;
    end
  end

  // Read pointer advances only over committed words
  always_comb begin
    rd_en_s = ren & ~empty_s;
    if (rd_en_s) begin
      rptr_d = rptr_q + ONE_C;
    end else begin
      rptr_d = rptr_q;
    end
  end

  // Packet and drop counters
  always_comb begin
    case ({commit_s, rd_done_s})
      2'b10:   cnt_d = cnt_q + ONE_C;
      2'b01:   cnt_d = cnt_q - ONE_C;
      default: cnt_d = cnt_q;
    endcase
    if (drop_inc_s && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end else begin
      drop_d = drop_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q   <= '0;
      cptr_q   <= '0;
      rptr_q   <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      drop_q   <= 16'd0;
      rvalid_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      cptr_q   <= cptr_d;
      rptr_q   <= rptr_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
      rvalid_q <= rd_en_s;
    end
  end

  // Memory write port
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[wptr_q[ADDR_WIDTH-1:0]] <= {wlast, wdata};
    end
  end

  // Registered read port; holds its value when no read is accepted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rword_q <= '0;
    end else if (rd_en_s) begin
      rword_q <= mem[rptr_q[ADDR_WIDTH-1:0]];
    end else begin
      rword_q <= rword_q;
    end
  end

  assign full     = full_s;
  assign afull    = afull_s;
  assign empty    = empty_s;
  assign used     = used_s;
  assign pkt_cnt  = cnt_q - {{ADDR_WIDTH{1'b0}}, rd_done_s};
  assign drop_cnt = drop_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rword_q[W_EL-1:0];
  assign rlast    = rword_q[W_EL];

endmodule

// File: tb/tb_pkt_fifo_sync.sv
// Directed bench for pkt_fifo_sync using a 16-word instance.
module tb_pkt_fifo_sync;

  localparam int AW    = 4;
  localparam int WEL   = 20;
  localparam int SLACK = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            wen, wlast, wabort, ren;
  logic [WEL-1:0]  wdata;
  logic            full, afull, rlast, rvalid, empty;
  logic [WEL-1:0]  rdata;
  logic [AW:0]     used, pkt_cnt;
  logic [15:0]     drop_cnt;

  int n_chk = 0;
  int n_err = 0;

  pkt_fifo_sync #(.ADDR_WIDTH(AW), .W_EL(WEL), .AFULL_SLACK(SLACK)) dut (
    .clk(clk), .reset(reset),
    .wen(wen), .wdata(wdata), .wlast(wlast), .wabort(wabort),
    .full(full), .afull(afull),
    .ren(ren), .rdata(rdata), .rlast(rlast), .rvalid(rvalid),
    .empty(empty), .used(used), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: apply inputs, pass the edge, sample 1 time unit later
  task automatic step(input logic w, input logic [WEL-1:0] d, input logic l,
                      input logic a, input logic r);
    wen = w; wdata = d; wlast = l; wabort = a; ren = r;
    @(posedge clk);
    #1;
    wen = 1'b0; wlast = 1'b0; wabort = 1'b0; ren = 1'b0; wdata = '0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_afull"}, 32'(afull), 32'd0);
    chk({tag, "_used"}, 32'(used), 32'd0);
    chk({tag, "_pkt"}, 32'(pkt_cnt), 32'd0);
    chk({tag, "_drop"}, 32'(drop_cnt), 32'd0);
    chk({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    chk({tag, "_rdata"}, 32'(rdata), 32'd0);
    chk({tag, "_rlast"}, 32'(rlast), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    wen = 1'b0; wlast = 1'b0; wabort = 1'b0; ren = 1'b0; wdata = '0;
    #12;
    chk_reset_state("rst");
    @(negedge clk);
    reset = 1'b1;

    // 3-word packet becomes visible only after its last word
    step(1'b1, 20'hAAAA1, 1'b0, 1'b0, 1'b0);
    chk("t1_empty_a", 32'(empty), 32'd1);
    chk("t1_used_a", 32'(used), 32'd1);
    step(1'b1, 20'hBBBB2, 1'b0, 1'b0, 1'b0);
    chk("t1_empty_b", 32'(empty), 32'd1);
    step(1'b1, 20'hCCCC3, 1'b1, 1'b0, 1'b0);
    chk("t1_empty_c", 32'(empty), 32'd0);
    chk("t1_pkt", 32'(pkt_cnt), 32'd1);
    chk("t1_used_c", 32'(used), 32'd3);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("t1_rv_a", 32'(rvalid), 32'd1);
    chk("t1_rd_a", 32'(rdata), 32'hAAAA1);
    chk("t1_rl_a", 32'(rlast), 32'd0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("t1_rd_b", 32'(rdata), 32'hBBBB2);
    chk("t1_rl_b", 32'(rlast), 32'd0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("t1_rd_c", 32'(rdata), 32'hCCCC3);
    chk("t1_rl_c", 32'(rlast), 32'd1);
    chk("t1_empty_end", 32'(empty), 32'd1);
    chk("t1_pkt_end", 32'(pkt_cnt), 32'd0);
    chk("t1_used_end", 32'(used), 32'd0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("t1_rv_idle", 32'(rvalid), 32'd0);
    chk("t1_rd_hold", 32'(rdata), 32'hCCCC3);
    chk("t1_rl_hold", 32'(rlast), 32'd1);

    // Abort mid-packet, then an intact packet
    step(1'b1, 20'h11111, 1'b0, 1'b0, 1'b0);
    step(1'b1, 20'h22222, 1'b0, 1'b0, 1'b0);
    chk("t2_used_pre", 32'(used), 32'd2);
    step(1'b1, 20'h33333, 1'b0, 1'b1, 1'b0);
    chk("t2_used", 32'(used), 32'd0);
    chk("t2_empty", 32'(empty), 32'd1);
    chk("t2_drop", 32'(drop_cnt), 32'd1);
    step(1'b1, 20'hD0D0D, 1'b0, 1'b0, 1'b0);
    step(1'b1, 20'hE0E0E, 1'b1, 1'b0, 1'b0);
    chk("t2_empty_post", 32'(empty), 32'd0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("t2_rd_d", 32'(rdata), 32'hD0D0D);
    chk("t2_rl_d", 32'(rlast), 32'd0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("t2_rd_e", 32'(rdata), 32'hE0E0E);
    chk("t2_rl_e", 32'(rlast), 32'd1);

    // Almost-full threshold and full with a committed 16-word packet
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, WEL'(20'h10000 + i), (i == 16), 1'b0, 1'b0);
      if (i == 11) chk("t3_afull_11", 32'(afull), 32'd0);
      if (i == 12) begin
        chk("t3_afull_12", 32'(afull), 32'd1);
        chk("t3_full_12", 32'(full), 32'd0);
      end
      if (i == 16) begin
        chk("t3_full_16", 32'(full), 32'd1);
        chk("t3_used_16", 32'(used), 32'd16);
        chk("t3_pkt_16", 32'(pkt_cnt), 32'd1);
      end
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("t3_rd_1", 32'(rdata), 32'h10001);
    chk("t3_full_clr", 32'(full), 32'd0);
    chk("t3_used_15", 32'(used), 32'd15);
    for (int i = 2; i <= 16; i++) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      chk("t3_rd", 32'(rdata), 32'h10000 + 32'(i));
      chk("t3_rl", 32'(rlast), 32'(i == 16));
    end
    chk("t3_empty_end", 32'(empty), 32'd1);

    // 18-word packet overflows and is dropped whole
    for (int i = 1; i <= 18; i++) begin
      step(1'b1, WEL'(20'h20000 + i), (i == 18), 1'b0, 1'b0);
      if (i == 16) chk("t4_full_16", 32'(full), 32'd1);
      if (i == 17) begin
        chk("t4_used_17", 32'(used), 32'd16);
        chk("t4_drop_17", 32'(drop_cnt), 32'd1);
      end
    end
    chk("t4_used", 32'(used), 32'd0);
    chk("t4_drop", 32'(drop_cnt), 32'd2);
    chk("t4_pkt", 32'(pkt_cnt), 32'd0);
    chk("t4_empty", 32'(empty), 32'd1);
    chk("t4_full", 32'(full), 32'd0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("t4_rv", 32'(rvalid), 32'd0);

    // Stream of single-word packets with simultaneous reads
    for (int i = 0; i < 100; i++) begin
      step(1'b1, WEL'(20'h30000 + i), 1'b1, 1'b0, 1'b1);
      chk("t5_rv", 32'(rvalid), 32'(i > 0));
      if (i > 0) begin
        chk("t5_rd", 32'(rdata), 32'h30000 + 32'(i - 1));
        chk("t5_rl", 32'(rlast), 32'd1);
      end
      chk("t5_pkt_max", 32'(pkt_cnt <= 5'd2), 32'd1);
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("t5_rd_last", 32'(rdata), 32'h30063);
    chk("t5_rv_last", 32'(rvalid), 32'd1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("t5_rv_done", 32'(rvalid), 32'd0);
    chk("t5_drop", 32'(drop_cnt), 32'd2);
    chk("t5_empty", 32'(empty), 32'd1);
    chk("t5_pkt", 32'(pkt_cnt), 32'd0);

    // Reset mid-packet with committed data present
    step(1'b1, 20'h4F4F4, 1'b1, 1'b0, 1'b0);
    step(1'b1, 20'h50505, 1'b1, 1'b0, 1'b1);
    step(1'b1, 20'h60606, 1'b0, 1'b0, 1'b0);
    chk("t6_pre_rd", 32'(rdata), 32'h4F4F4);
    chk("t6_pre_pkt", 32'(pkt_cnt), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_state("t6");
    #3;
    reset = 1'b1;
    step(1'b1, 20'h77777, 1'b1, 1'b0, 1'b0);
    chk("t6_used", 32'(used), 32'd1);
    chk("t6_pkt", 32'(pkt_cnt), 32'd1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("t6_rd", 32'(rdata), 32'h77777);
    chk("t6_rl", 32'(rlast), 32'd1);
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_drop", 32'(drop_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
